// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter
//   Round-robin arbiter sharing one resource among N requesters. Priority is a
//   one-hot ring pointer that rotates past the winner on every release. Grants
//   are exclusive, registered, and held until the requester drops its request
//   or the hold limit (captured at grant start) expires.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req         request vector, bit i = requester i
//   max_hold    max consecutive grant cycles (0 = unlimited), sampled at grant start
//   grant       one-hot registered grant, zero when idle
//   grant_valid OR of grant, registered
//   grant_idx   binary index of the granted requester, 0 when idle
//   prio        one-hot priority pointer (highest-priority requester)
//   timeout     one-cycle pulse after a grant is revoked by the hold limit
module rr_ring_arbiter #(
  parameter int N      = 4,
  parameter int IDX_W  = 2,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [HOLD_W-1:0] max_hold,
  output logic [N-1:0]      grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [N-1:0]      prio,
  output logic              timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            r_state, w_state_next;
  logic [N-1:0]      r_grant, w_grant_next;
  logic              r_valid, w_valid_next;
  logic [IDX_W-1:0]  r_idx, w_idx_next;
  logic [N-1:0]      r_prio, w_prio_next;
  logic              r_timeout, w_timeout_next;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
  logic [HOLD_W-1:0] r_hold_limit, w_hold_limit_next;

  logic [IDX_W-1:0]  w_prio_idx;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_found;

  // Binary position of the one-hot priority pointer.
  always_comb begin
    w_prio_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_prio[i]) w_prio_idx = IDX_W'(i);
    end
  end

  // Circular scan upward from the priority position; first set request wins.
  always_comb begin
    int c;
    c         = 0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int off = 0; off < N; off++) begin
      c = (int'(w_prio_idx) + off) % N;
      if (!w_found && req[c[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = c[IDX_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_prio       <= N'(1);
      r_timeout    <= 1'b0;
      r_hold_cnt   <= '0;
      r_hold_limit <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_valid      <= w_valid_next;
      r_idx        <= w_idx_next;
      r_prio       <= w_prio_next;
      r_timeout    <= w_timeout_next;
      r_hold_cnt   <= w_hold_cnt_next;
      r_hold_limit <= w_hold_limit_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_valid_next      = r_valid;
    w_idx_next        = r_idx;
    w_prio_next       = r_prio;
    w_timeout_next    = 1'b0;
    w_hold_cnt_next   = r_hold_cnt;
    w_hold_limit_next = r_hold_limit;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next      = GRANT;
          w_grant_next      = N'(1) << w_win_idx;
          w_valid_next      = 1'b1;
          w_idx_next        = w_win_idx;
          w_hold_limit_next = max_hold;
          w_hold_cnt_next   = '0;
        end
      end
      GRANT: begin
        // A dropped request takes precedence over the limit: no timeout then.
        if ((req & r_grant) == '0 ||
            (r_hold_limit != '0 && r_hold_cnt == r_hold_limit - HOLD_W'(1))) begin
          w_state_next   = IDLE;
          w_grant_next   = '0;
          w_valid_next   = 1'b0;
          w_idx_next     = '0;
          // Pointer moves to the bit just past the winner: ring rotation.
          w_prio_next    = {r_grant[N-2:0], r_grant[N-1]};
          w_timeout_next = ((req & r_grant) != '0);
        end else if (r_hold_cnt != '1) begin
          w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;
  assign prio        = r_prio;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
module tb_rr_ring_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] max_hold = '0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] prio;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_ring_arbiter #(.N(4), .IDX_W(2), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .max_hold(max_hold),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .prio(prio), .timeout(timeout)
  );

  // One cycle of stimulus with the outputs expected after the next edge.
  typedef struct packed {
    logic [3:0] req;
    logic [7:0] mh;
    logic [3:0] g;
    logic [3:0] p;
    logic       to;
  } vec_t;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] p;
    logic       to;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic add(input logic [3:0] r, input logic [7:0] mh, input logic [3:0] g,
                     input logic [3:0] p, input logic to, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{r, mh, g, p, to});
  endtask

  task automatic check(input string name, input int id, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int id, input logic [3:0] g,
                           input logic [3:0] p, input logic to);
    check({tag, ".grant"},   id, int'(grant), int'(g));
    check({tag, ".valid"},   id, int'(grant_valid), int'(|g));
    check({tag, ".idx"},     id, int'(grant_idx), int'(idx_of(g)));
    check({tag, ".prio"},    id, int'(prio), int'(p));
    check({tag, ".timeout"}, id, int'(timeout), int'(to));
  endtask

  initial begin
    exp_t e;

    // Single requester, unlimited hold, 5 grant cycles
    add(4'b0100, 8'd0, 4'b0100, 4'b0001, 1'b0, 5);
    add(4'b0000, 8'd0, 4'b0000, 4'b1000, 1'b0, 2);
    // Grant to 3, then wrap: req 1001 -> 0 wins, then 3
    add(4'b1000, 8'd0, 4'b1000, 4'b1000, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0001, 1'b0, 1);
    add(4'b1001, 8'd0, 4'b0001, 4'b0001, 1'b0, 2);
    add(4'b1000, 8'd0, 4'b0000, 4'b0010, 1'b0, 1);
    add(4'b1000, 8'd0, 4'b1000, 4'b0010, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0001, 1'b0, 1);
    // Priority skip: prio 0100, req 0011 -> 0 wins via wrap
    add(4'b0010, 8'd0, 4'b0010, 4'b0001, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0100, 1'b0, 1);
    add(4'b0011, 8'd0, 4'b0001, 4'b0100, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0010, 1'b0, 1);
    // Bring prio back to 0001
    add(4'b1000, 8'd0, 4'b1000, 4'b0010, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0001, 1'b0, 1);
    // Fairness: all request, hold limit 3
    add(4'b1111, 8'd3, 4'b0001, 4'b0001, 1'b0, 3);
    add(4'b1111, 8'd3, 4'b0000, 4'b0010, 1'b1, 1);
    add(4'b1111, 8'd3, 4'b0010, 4'b0010, 1'b0, 3);
    add(4'b1111, 8'd3, 4'b0000, 4'b0100, 1'b1, 1);
    add(4'b1111, 8'd3, 4'b0100, 4'b0100, 1'b0, 3);
    add(4'b1111, 8'd3, 4'b0000, 4'b1000, 1'b1, 1);
    add(4'b1111, 8'd3, 4'b1000, 4'b1000, 1'b0, 3);
    add(4'b1111, 8'd3, 4'b0000, 4'b0001, 1'b1, 1);
    add(4'b1111, 8'd3, 4'b0001, 4'b0001, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0010, 1'b0, 1);
    // Limit 4, request drops on the edge that would hit the limit
    add(4'b0010, 8'd4, 4'b0010, 4'b0010, 1'b0, 4);
    add(4'b0000, 8'd4, 4'b0000, 4'b0100, 1'b0, 2);
    // max_hold raised mid-grant: captured limit 2 still applies
    add(4'b0100, 8'd2, 4'b0100, 4'b0100, 1'b0, 1);
    add(4'b0100, 8'd7, 4'b0100, 4'b0100, 1'b0, 1);
    add(4'b0100, 8'd7, 4'b0000, 4'b1000, 1'b1, 1);
    add(4'b0000, 8'd7, 4'b0000, 4'b1000, 1'b0, 1);
    // max_hold 1: one-cycle grants, idle gap before regranting same requester
    add(4'b0001, 8'd1, 4'b0001, 4'b1000, 1'b0, 1);
    add(4'b0001, 8'd1, 4'b0000, 4'b0010, 1'b1, 1);
    add(4'b0001, 8'd1, 4'b0001, 4'b0010, 1'b0, 1);
    add(4'b0000, 8'd0, 4'b0000, 4'b0010, 1'b0, 1);
    // Idle for 10 cycles
    add(4'b0000, 8'd0, 4'b0000, 4'b0010, 1'b0, 10);
    // Grant to 2 before the mid-grant reset
    add(4'b0100, 8'd0, 4'b0100, 4'b0010, 1'b0, 1);

    // Reset values while rst is held
    #12;
    check_all("reset", -1, 4'b0000, 4'b0001, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req      = tbl[i].req;
      max_hold = tbl[i].mh;
      sb.push_back('{tbl[i].g, tbl[i].p, tbl[i].to, i});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL scoreboard step %0d: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        check_all("vec", e.id, e.g, e.p, e.to);
        $display("step %0d req=%b mh=%0d grant=%b idx=%0d prio=%b to=%b",
                 e.id, tbl[i].req, tbl[i].mh, grant, grant_idx, prio, timeout);
      end
    end

    // Asynchronous reset mid-grant: outputs clear before any clock edge
    #3 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 4'b0000, 4'b0001, 1'b0);
    @(posedge clk); #1;
    req = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst", 1, 4'b0000, 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
